// File: rtl/pc_stack.sv
// Program counter with an integrated circular return-address stack.
// Supports increment, jump, conditional relative branch, call and return.
module pc_stack #(
  parameter int             AW       = 8,
  parameter int             DEPTH    = 4,
  parameter logic [AW-1:0]  RESET_PC = {AW{1'b0}}
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [2:0]                 op,
  input  logic [AW-1:0]              target,
  input  logic [AW-1:0]              offset,
  input  logic                       cond,
  input  logic                       clr_err,
  output logic [AW-1:0]              pcout,
  output logic [AW-1:0]              top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf,
  output logic                       unf
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0] DEPTH_0   = {DW{1'b0}};

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_JUMP = 3'b010;
  localparam logic [2:0] OP_BRC  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PTR_LAST) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    ptr_dec = (p == {PW{1'b0}}) ? PTR_LAST : p - PW'(1);
  endfunction

  logic [AW-1:0] mem_r [DEPTH];
  logic [AW-1:0] pcout_r;
  logic [AW-1:0] top_r;
  logic [PW-1:0] ptr_r;
  logic [DW-1:0] depth_r;
  logic          empty_r;
  logic          full_r;
  logic          ovf_r;
  logic          unf_r;

  logic [AW-1:0] pc_inc_s;
  logic [AW-1:0] pc_nxt_s;
  logic [AW-1:0] top_nxt_s;
  logic [PW-1:0] ptr_nxt_s;
  logic [DW-1:0] depth_nxt_s;
  logic          push_s;
  logic          ovf_set_s;
  logic          unf_set_s;

  assign pc_inc_s = pcout_r + AW'(1);

  // Next-state decode of the operation; a full push overwrites the oldest slot.
  always_comb begin
    pc_nxt_s    = pcout_r;
    ptr_nxt_s   = ptr_r;
    depth_nxt_s = depth_r;
    push_s      = 1'b0;
    ovf_set_s   = 1'b0;
    unf_set_s   = 1'b0;
    if (en) begin
      case (op)
        OP_HOLD: pc_nxt_s = pcout_r;
        OP_INC:  pc_nxt_s = pc_inc_s;
        OP_JUMP: pc_nxt_s = target;
        OP_BRC: begin
          if (cond) begin
            pc_nxt_s = pcout_r + offset;
          end else begin
            pc_nxt_s = pc_inc_s;
          end
        end
        OP_CALL: begin
          push_s    = 1'b1;
          pc_nxt_s  = target;
          ptr_nxt_s = ptr_inc(ptr_r);
          if (depth_r == DEPTH_MAX) begin
            ovf_set_s = 1'b1;
          end else begin
            depth_nxt_s = depth_r + DW'(1);
          end
        end
        OP_RET: begin
          if (depth_r == DEPTH_0) begin
            pc_nxt_s  = pc_inc_s;
            unf_set_s = 1'b1;
          end else begin
            pc_nxt_s    = mem_r[ptr_r];
            ptr_nxt_s   = ptr_dec(ptr_r);
            depth_nxt_s = depth_r - DW'(1);
          end
        end
        default: pc_nxt_s = pcout_r;
      endcase
    end else begin
      pc_nxt_s = pcout_r;
    end
  end

  // Top-of-stack value as it will appear after this edge.
  always_comb begin
    top_nxt_s = {AW{1'b0}};
    if (depth_nxt_s == DEPTH_0) begin
      top_nxt_s = {AW{1'b0}};
    end else if (push_s) begin
      top_nxt_s = pc_inc_s;
    end else begin
      top_nxt_s = mem_r[ptr_nxt_s];
    end
  end

  // Control state and registered outputs; error set has priority over clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcout_r <= RESET_PC;
      top_r   <= {AW{1'b0}};
      ptr_r   <= {PW{1'b0}};
      depth_r <= DEPTH_0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      pcout_r <= pc_nxt_s;
      top_r   <= top_nxt_s;
      ptr_r   <= ptr_nxt_s;
      depth_r <= depth_nxt_s;
      empty_r <= (depth_nxt_s == DEPTH_0);
      full_r  <= (depth_nxt_s == DEPTH_MAX);
      ovf_r   <= ovf_set_s | (ovf_r & ~clr_err);
      unf_r   <= unf_set_s | (unf_r & ~clr_err);
    end
  end

  // Stack storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[ptr_nxt_s] <= pc_inc_s;
    end
  end

  assign pcout = pcout_r;
  assign top   = top_r;
  assign depth = depth_r;
  assign empty = empty_r;
  assign full  = full_r;
  assign ovf   = ovf_r;
  assign unf   = unf_r;

endmodule

// File: tb/tb_pc_stack.sv
// Directed self-checking bench for pc_stack at AW=8/DEPTH=4 and AW=12/DEPTH=8.
module tb_pc_stack;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: AW=8, DEPTH=4
  logic       a_en, a_cond, a_clr;
  logic [2:0] a_op;
  logic [7:0] a_target, a_offset, a_pc, a_top;
  logic [2:0] a_depth;
  logic       a_empty, a_full, a_ovf, a_unf;

  // Instance B: AW=12, DEPTH=8
  logic        b_en, b_cond, b_clr;
  logic [2:0]  b_op;
  logic [11:0] b_target, b_offset, b_pc, b_top;
  logic [3:0]  b_depth;
  logic        b_empty, b_full, b_ovf, b_unf;

  int total = 0;
  int bad   = 0;

  pc_stack #(.AW(8), .DEPTH(4), .RESET_PC(8'h00)) dut_a (
    .clk(clk), .reset(reset), .en(a_en), .op(a_op), .target(a_target),
    .offset(a_offset), .cond(a_cond), .clr_err(a_clr), .pcout(a_pc),
    .top(a_top), .depth(a_depth), .empty(a_empty), .full(a_full),
    .ovf(a_ovf), .unf(a_unf)
  );

  pc_stack #(.AW(12), .DEPTH(8), .RESET_PC(12'h000)) dut_b (
    .clk(clk), .reset(reset), .en(b_en), .op(b_op), .target(b_target),
    .offset(b_offset), .cond(b_cond), .clr_err(b_clr), .pcout(b_pc),
    .top(b_top), .depth(b_depth), .empty(b_empty), .full(b_full),
    .ovf(b_ovf), .unf(b_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic opa(input logic [2:0] o, input logic [7:0] t, input logic [7:0] f,
                     input logic c, input logic e, input logic ce);
    a_op = o; a_target = t; a_offset = f; a_cond = c; a_en = e; a_clr = ce;
    @(posedge clk); #1;
  endtask

  task automatic opb(input logic [2:0] o, input logic [11:0] t, input logic [11:0] f,
                     input logic c);
    b_op = o; b_target = t; b_offset = f; b_cond = c; b_en = 1'b1; b_clr = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    a_en = 1'b0; a_op = 3'b000; a_target = 8'h00; a_offset = 8'h00; a_cond = 1'b0; a_clr = 1'b0;
    b_en = 1'b0; b_op = 3'b000; b_target = 12'h000; b_offset = 12'h000; b_cond = 1'b0; b_clr = 1'b0;
    #12 reset = 1'b0;

    chk("rst_pc", a_pc, 8'h00);
    chk("rst_top", a_top, 8'h00);
    chk("rst_depth", a_depth, 3'd0);
    chk("rst_empty", a_empty, 1'b1);
    chk("rst_full", a_full, 1'b0);
    chk("rst_ovf", a_ovf, 1'b0);
    chk("rst_unf", a_unf, 1'b0);

    for (int i = 1; i <= 5; i++) begin
      opa(3'b001, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("inc_seq", a_pc, i);
    end
    // asynchronous reset mid-cycle
    a_en = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("async_rst_pc", a_pc, 8'h00);
    chk("async_rst_depth", a_depth, 3'd0);
    #1 reset = 1'b0;

    opa(3'b010, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b0); chk("jump_fe", a_pc, 8'hFE);
    opa(3'b001, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0); chk("inc_ff", a_pc, 8'hFF);
    opa(3'b001, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0); chk("inc_wrap", a_pc, 8'h00);
    opa(3'b001, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0); chk("inc_01", a_pc, 8'h01);
    opa(3'b011, 8'h00, 8'hFD, 1'b1, 1'b1, 1'b0); chk("brc_back3", a_pc, 8'hFE);
    opa(3'b011, 8'h00, 8'hFD, 1'b0, 1'b1, 1'b0); chk("brc_not_taken", a_pc, 8'hFF);
    opa(3'b011, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0); chk("brc_self_loop", a_pc, 8'hFF);

    // nested calls
    opa(3'b010, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0);
    opa(3'b100, 8'h40, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("call1_pc", a_pc, 8'h40); chk("call1_top", a_top, 8'h11);
    opa(3'b100, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("call2_pc", a_pc, 8'h80); chk("call2_depth", a_depth, 3'd2); chk("call2_top", a_top, 8'h41);
    opa(3'b101, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("ret1_pc", a_pc, 8'h41); chk("ret1_top", a_top, 8'h11);
    opa(3'b101, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("ret2_pc", a_pc, 8'h11); chk("ret2_empty", a_empty, 1'b1); chk("ret2_top", a_top, 8'h00);

    // overflow wrap
    opa(3'b010, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    opa(3'b100, 8'h20, 8'h00, 1'b0, 1'b1, 1'b0);
    opa(3'b100, 8'h30, 8'h00, 1'b0, 1'b1, 1'b0);
    opa(3'b100, 8'h40, 8'h00, 1'b0, 1'b1, 1'b0);
    opa(3'b100, 8'h50, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("fill_full", a_full, 1'b1); chk("fill_ovf", a_ovf, 1'b0);
    opa(3'b100, 8'h60, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("ovf_pc", a_pc, 8'h60); chk("ovf_flag", a_ovf, 1'b1);
    chk("ovf_depth", a_depth, 3'd4); chk("ovf_full", a_full, 1'b1); chk("ovf_top", a_top, 8'h51);
    opa(3'b101, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0); chk("wret1", a_pc, 8'h51); chk("wret1_top", a_top, 8'h41);
    opa(3'b101, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0); chk("wret2", a_pc, 8'h41);
    opa(3'b101, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0); chk("wret3", a_pc, 8'h31);
    opa(3'b101, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0); chk("wret4", a_pc, 8'h21); chk("wret4_empty", a_empty, 1'b1);
    opa(3'b101, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("unf_pc", a_pc, 8'h22); chk("unf_flag", a_unf, 1'b1); chk("unf_depth", a_depth, 3'd0);
    chk("unf_ovf_sticky", a_ovf, 1'b1);

    // enable gating and error clearing
    opa(3'b100, 8'h90, 8'h00, 1'b0, 1'b1, 1'b0);
    opa(3'b100, 8'h99, 8'h00, 1'b0, 1'b0, 1'b0);
    opa(3'b010, 8'h77, 8'h00, 1'b0, 1'b0, 1'b0);
    opa(3'b100, 8'h99, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("en0_pc", a_pc, 8'h90); chk("en0_depth", a_depth, 3'd1); chk("en0_top", a_top, 8'h23);
    chk("en0_unf_held", a_unf, 1'b1);
    opa(3'b010, 8'h77, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_ovf", a_ovf, 1'b0); chk("clr_unf", a_unf, 1'b0); chk("clr_pc_held", a_pc, 8'h90);
    opa(3'b101, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0); chk("ret_23", a_pc, 8'h23);
    opa(3'b101, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("set_wins_unf", a_unf, 1'b1); chk("set_wins_pc", a_pc, 8'h24);
    opa(3'b000, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1); chk("hold_clr_unf", a_unf, 1'b0);

    // reserved ops
    opa(3'b100, 8'hA0, 8'h00, 1'b0, 1'b1, 1'b0);
    opa(3'b110, 8'h55, 8'h01, 1'b1, 1'b1, 1'b0);
    opa(3'b111, 8'h55, 8'h01, 1'b1, 1'b1, 1'b0);
    chk("rsv_pc", a_pc, 8'hA0); chk("rsv_depth", a_depth, 3'd1); chk("rsv_top", a_top, 8'h25);
    chk("rsv_ovf", a_ovf, 1'b0); chk("rsv_unf", a_unf, 1'b0);
    a_en = 1'b0;

    // second configuration
    chk("b_rst_pc", b_pc, 12'h000); chk("b_rst_empty", b_empty, 1'b1);
    opb(3'b010, 12'hFFF, 12'h000, 1'b0); chk("b_jump", b_pc, 12'hFFF);
    opb(3'b001, 12'h000, 12'h000, 1'b0); chk("b_wrap", b_pc, 12'h000);
    for (int i = 0; i < 8; i++) begin
      opb(3'b100, 12'((i + 1) * 256), 12'h000, 1'b0);
      chk("b_call_depth", b_depth, i + 1);
      chk("b_call_top", b_top, 12'(i * 256 + 1));
    end
    chk("b_full", b_full, 1'b1); chk("b_no_ovf", b_ovf, 1'b0); chk("b_pc800", b_pc, 12'h800);
    opb(3'b100, 12'h900, 12'h000, 1'b0);
    chk("b_ovf", b_ovf, 1'b1); chk("b_ovf_depth", b_depth, 4'd8); chk("b_ovf_top", b_top, 12'h801);
    opb(3'b110, 12'h123, 12'h001, 1'b1);
    opb(3'b111, 12'h123, 12'h001, 1'b1);
    chk("b_rsv_pc", b_pc, 12'h900); chk("b_rsv_depth", b_depth, 4'd8); chk("b_rsv_top", b_top, 12'h801);
    opb(3'b101, 12'h000, 12'h000, 1'b0);
    chk("b_ret_pc", b_pc, 12'h801); chk("b_ret_top", b_top, 12'h701); chk("b_ret_depth", b_depth, 4'd7);
    opb(3'b011, 12'h000, 12'hFFF, 1'b1); chk("b_brc_m1", b_pc, 12'h800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
